// File: rtl/trap_sequencer_if.sv
// CSR write port of the trap sequencer.
// The master (sequencer) holds csr_wr_valid with stable addr/data until the
// slave (CSR file) returns csr_wr_ready; the transfer happens on that clock edge.
//   csr_wr_valid  master -> slave  write request
//   csr_wr_addr   master -> slave  12-bit CSR address
//   csr_wr_data   master -> slave  XLEN-bit write data
//   csr_wr_ready  slave -> master  write accepted this cycle
interface trap_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            csr_wr_valid;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;
  logic            csr_wr_ready;

  modport master (
    output csr_wr_valid,
    output csr_wr_addr,
    output csr_wr_data,
    input  csr_wr_ready
  );

  modport slave (
    input  csr_wr_valid,
    input  csr_wr_addr,
    input  csr_wr_data,
    output csr_wr_ready
  );

endinterface

// File: rtl/trap_sequencer.sv
// Trap entry / trap return sequencer.
// Arbitrates exception > interrupt > mret > sret while idle. A trap flushes the
// pipeline, writes EPC, CAUSE, TVAL and STATUS through one CSR write port,
// redirects fetch to the trap vector and switches privilege. A return flushes,
// rewrites STATUS, redirects to MEPC/SEPC and drops privilege.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   exc_*_i                    exception request + payload (cause/tval/pc/target priv/vector)
//   irq_*_i                    interrupt request + payload (cause/pc/target priv/vector)
//   mret_i, sret_i             return instruction committed
//   mepc_in_i, sepc_in_i       current MEPC / SEPC
//   status_in_i                current mstatus
//   csr_wr                     CSR write port (master side)
//   flush_o                    pipeline flush, single cycle
//   busy_o                     sequencer not idle
//   pc_redirect_valid_o/_target_o  fetch redirect
//   trap_taken_o               pulse in the redirect cycle of a trap
//   priv_mode_o                current privilege (00 U, 01 S, 11 M)
module trap_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                exc_valid_i,
  input  logic [XLEN-1:0]     exc_cause_i,
  input  logic [XLEN-1:0]     exc_tval_i,
  input  logic [XLEN-1:0]     exc_pc_i,
  input  logic [1:0]          exc_target_priv_i,
  input  logic [XLEN-1:0]     exc_vector_i,

  input  logic                irq_valid_i,
  input  logic [XLEN-1:0]     irq_cause_i,
  input  logic [XLEN-1:0]     irq_pc_i,
  input  logic [1:0]          irq_target_priv_i,
  input  logic [XLEN-1:0]     irq_vector_i,

  input  logic                mret_i,
  input  logic                sret_i,

  input  logic [XLEN-1:0]     mepc_in_i,
  input  logic [XLEN-1:0]     sepc_in_i,
  input  logic [XLEN-1:0]     status_in_i,

  trap_sequencer_if.master    csr_wr,

  output logic                flush_o,
  output logic                busy_o,
  output logic                pc_redirect_valid_o,
  output logic [XLEN-1:0]     pc_redirect_target_o,
  output logic                trap_taken_o,
  output logic [1:0]          priv_mode_o
);

  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivM = 2'b11;

  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;
  localparam logic [11:0] AddrSepc    = 12'h141;
  localparam logic [11:0] AddrScause  = 12'h142;
  localparam logic [11:0] AddrStval   = 12'h143;
  localparam logic [11:0] AddrMstatus = 12'h300;

  // mstatus field positions
  localparam int unsigned BitSie  = 1;
  localparam int unsigned BitMie  = 3;
  localparam int unsigned BitSpie = 5;
  localparam int unsigned BitMpie = 7;
  localparam int unsigned BitSpp  = 8;
  localparam int unsigned BitMppL = 11;
  localparam int unsigned BitMppH = 12;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StWrEpc,
    StWrCause,
    StWrTval,
    StWrStatus,
    StRedirect,
    StRetStatus
  } state_e;

  state_e          state_q, state_d;
  logic            is_ret_q, is_ret_d;     // sequence is an mret/sret
  logic            is_mret_q, is_mret_d;   // return flavour when is_ret_q
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] vec_q, vec_d;
  logic [1:0]      tgt_priv_q, tgt_priv_d;
  logic [1:0]      old_priv_q, old_priv_d;
  logic [1:0]      new_priv_q, new_priv_d; // applied on the edge leaving StRedirect
  logic [1:0]      priv_q, priv_d;

  logic            tgt_is_m;
  logic [XLEN-1:0] status_trap;
  logic [XLEN-1:0] status_ret;
  logic [1:0]      ret_priv;
  logic            wr_valid;
  logic [11:0]     wr_addr;
  logic [XLEN-1:0] wr_data;

  assign tgt_is_m = (tgt_priv_q == PrivM);

  // STATUS images for trap entry and return, built from the live mstatus value.
  always_comb begin
    status_trap = status_in_i;
    status_ret  = status_in_i;
    ret_priv    = PrivU;

    if (tgt_is_m) begin
      status_trap[BitMppH:BitMppL] = old_priv_q;
      status_trap[BitMpie]         = status_in_i[BitMie];
      status_trap[BitMie]          = 1'b0;
    end else begin
      status_trap[BitSpp]  = old_priv_q[0];
      status_trap[BitSpie] = status_in_i[BitSie];
      status_trap[BitSie]  = 1'b0;
    end

    if (is_mret_q) begin
      status_ret[BitMie]          = status_in_i[BitMpie];
      status_ret[BitMpie]         = 1'b1;
      status_ret[BitMppH:BitMppL] = 2'b00;
      ret_priv                    = status_in_i[BitMppH:BitMppL];
    end else begin
      status_ret[BitSie]  = status_in_i[BitSpie];
      status_ret[BitSpie] = 1'b1;
      status_ret[BitSpp]  = 1'b0;
      ret_priv            = {1'b0, status_in_i[BitSpp]};
    end
  end

  // Next-state and request capture.
  always_comb begin
    state_d    = state_q;
    is_ret_d   = is_ret_q;
    is_mret_d  = is_mret_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    vec_d      = vec_q;
    tgt_priv_d = tgt_priv_q;
    old_priv_d = old_priv_q;
    new_priv_d = new_priv_q;
    priv_d     = priv_q;

    unique case (state_q)
      StIdle: begin
        if (exc_valid_i) begin
          // An interrupt raised in the same cycle stays pending upstream.
          is_ret_d   = 1'b0;
          is_mret_d  = 1'b0;
          pc_d       = exc_pc_i;
          cause_d    = exc_cause_i;
          tval_d     = exc_tval_i;
          vec_d      = exc_vector_i;
          tgt_priv_d = exc_target_priv_i;
          new_priv_d = exc_target_priv_i;
          old_priv_d = priv_q;
          state_d    = StFlush;
        end else if (irq_valid_i) begin
          is_ret_d   = 1'b0;
          is_mret_d  = 1'b0;
          pc_d       = irq_pc_i;
          cause_d    = irq_cause_i;
          tval_d     = '0;
          vec_d      = irq_vector_i;
          tgt_priv_d = irq_target_priv_i;
          new_priv_d = irq_target_priv_i;
          old_priv_d = priv_q;
          state_d    = StFlush;
        end else if (mret_i) begin
          // Illegal mret stays idle; upstream raises the exception.
          if (priv_q == PrivM) begin
            is_ret_d  = 1'b1;
            is_mret_d = 1'b1;
            state_d   = StFlush;
          end
        end else if (sret_i) begin
          if (priv_q != PrivU) begin
            is_ret_d  = 1'b1;
            is_mret_d = 1'b0;
            state_d   = StFlush;
          end
        end
      end
      StFlush:     state_d = is_ret_q ? StRetStatus : StWrEpc;
      StWrEpc:     if (csr_wr.csr_wr_ready) state_d = StWrCause;
      StWrCause:   if (csr_wr.csr_wr_ready) state_d = StWrTval;
      StWrTval:    if (csr_wr.csr_wr_ready) state_d = StWrStatus;
      StWrStatus:  if (csr_wr.csr_wr_ready) state_d = StRedirect;
      StRetStatus: begin
        if (csr_wr.csr_wr_ready) begin
          // Privilege comes from the STATUS value actually written.
          new_priv_d = ret_priv;
          state_d    = StRedirect;
        end
      end
      StRedirect: begin
        priv_d  = new_priv_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    wr_valid             = 1'b0;
    wr_addr              = '0;
    wr_data              = '0;
    flush_o              = 1'b0;
    pc_redirect_valid_o  = 1'b0;
    pc_redirect_target_o = '0;
    trap_taken_o         = 1'b0;

    unique case (state_q)
      StFlush: flush_o = 1'b1;
      StWrEpc: begin
        wr_valid = 1'b1;
        wr_addr  = tgt_is_m ? AddrMepc : AddrSepc;
        wr_data  = pc_q;
      end
      StWrCause: begin
        wr_valid = 1'b1;
        wr_addr  = tgt_is_m ? AddrMcause : AddrScause;
        wr_data  = cause_q;
      end
      StWrTval: begin
        wr_valid = 1'b1;
        wr_addr  = tgt_is_m ? AddrMtval : AddrStval;
        wr_data  = tval_q;
      end
      StWrStatus: begin
        wr_valid = 1'b1;
        wr_addr  = AddrMstatus;
        wr_data  = status_trap;
      end
      StRetStatus: begin
        wr_valid = 1'b1;
        wr_addr  = AddrMstatus;
        wr_data  = status_ret;
      end
      StRedirect: begin
        pc_redirect_valid_o = 1'b1;
        trap_taken_o        = ~is_ret_q;
        if (!is_ret_q) begin
          pc_redirect_target_o = vec_q;
        end else if (is_mret_q) begin
          pc_redirect_target_o = mepc_in_i;
        end else begin
          pc_redirect_target_o = sepc_in_i;
        end
      end
      default: ;
    endcase
  end

  assign csr_wr.csr_wr_valid = wr_valid;
  assign csr_wr.csr_wr_addr  = wr_addr;
  assign csr_wr.csr_wr_data  = wr_data;

  assign busy_o      = (state_q != StIdle);
  assign priv_mode_o = priv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_ret_q   <= 1'b0;
      is_mret_q  <= 1'b0;
      pc_q       <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      vec_q      <= '0;
      tgt_priv_q <= PrivM;
      old_priv_q <= PrivM;
      new_priv_q <= PrivM;
      priv_q     <= PrivM;
    end else begin
      state_q    <= state_d;
      is_ret_q   <= is_ret_d;
      is_mret_q  <= is_mret_d;
      pc_q       <= pc_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
      vec_q      <= vec_d;
      tgt_priv_q <= tgt_priv_d;
      old_priv_q <= old_priv_d;
      new_priv_q <= new_priv_d;
      priv_q     <= priv_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            exc_valid, irq_valid, mret, sret;
  logic [XLEN-1:0] exc_cause, exc_tval, exc_pc, exc_vector;
  logic [XLEN-1:0] irq_cause, irq_pc, irq_vector;
  logic [1:0]      exc_target_priv, irq_target_priv;
  logic [XLEN-1:0] mepc_in, sepc_in, status_in;
  logic            flush, busy, pc_redirect_valid, trap_taken;
  logic [XLEN-1:0] pc_redirect_target;
  logic [1:0]      priv_mode;

  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN)) csr_wr ();

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .exc_valid_i          (exc_valid),
    .exc_cause_i          (exc_cause),
    .exc_tval_i           (exc_tval),
    .exc_pc_i             (exc_pc),
    .exc_target_priv_i    (exc_target_priv),
    .exc_vector_i         (exc_vector),
    .irq_valid_i          (irq_valid),
    .irq_cause_i          (irq_cause),
    .irq_pc_i             (irq_pc),
    .irq_target_priv_i    (irq_target_priv),
    .irq_vector_i         (irq_vector),
    .mret_i               (mret),
    .sret_i               (sret),
    .mepc_in_i            (mepc_in),
    .sepc_in_i            (sepc_in),
    .status_in_i          (status_in),
    .csr_wr               (csr_wr),
    .flush_o              (flush),
    .busy_o               (busy),
    .pc_redirect_valid_o  (pc_redirect_valid),
    .pc_redirect_target_o (pc_redirect_target),
    .trap_taken_o         (trap_taken),
    .priv_mode_o          (priv_mode)
  );

  int vectors     = 0;
  int miscompares = 0;
  int busy_cnt    = 0;
  int flush_cnt   = 0;

  typedef struct {logic [11:0] addr; logic [XLEN-1:0] data;} wr_t;
  typedef struct {logic [XLEN-1:0] target; logic trap;} rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted CSR write and every redirect pops an expectation.
  always @(negedge clk) begin : monitor
    wr_t w;
    rd_t r;
    if (busy)  busy_cnt++;
    if (flush) flush_cnt++;
    if (rst_n && csr_wr.csr_wr_valid && csr_wr.csr_wr_ready) begin
      check("csr_write_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("csr_addr", 32'(csr_wr.csr_wr_addr), 32'(w.addr));
        check("csr_data", csr_wr.csr_wr_data, w.data);
      end
    end
    if (rst_n && pc_redirect_valid) begin
      check("redirect_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) begin
        r = rd_q.pop_front();
        check("redirect_target", pc_redirect_target, r.target);
        check("trap_taken", 32'(trap_taken), 32'(r.trap));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_rd(input logic [XLEN-1:0] t, input logic trap);
    rd_t r;
    r.target = t;
    r.trap   = trap;
    rd_q.push_back(r);
  endtask

  task automatic set_exc(input logic [XLEN-1:0] cause, input logic [XLEN-1:0] tval,
                         input logic [XLEN-1:0] pc, input logic [1:0] tgt,
                         input logic [XLEN-1:0] vec);
    exc_valid = 1'b1; exc_cause = cause; exc_tval = tval; exc_pc = pc;
    exc_target_priv = tgt; exc_vector = vec;
  endtask

  task automatic set_irq(input logic [XLEN-1:0] cause, input logic [XLEN-1:0] pc,
                         input logic [1:0] tgt, input logic [XLEN-1:0] vec);
    irq_valid = 1'b1; irq_cause = cause; irq_pc = pc;
    irq_target_priv = tgt; irq_vector = vec;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    check({tag, "_terminates"}, 32'(busy), 0);
  endtask

  task automatic finish_seq(input string tag, input int b0, input int f0,
                            input int exp_busy, input logic [1:0] exp_priv);
    check({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
    check({tag, "_flush_cycles"}, flush_cnt - f0, 1);
    check({tag, "_priv"}, 32'(priv_mode), 32'(exp_priv));
    check({tag, "_writes_drained"}, wr_q.size(), 0);
    check({tag, "_redirects_drained"}, rd_q.size(), 0);
  endtask

  // Requests already driven; the next edge is the capture edge.
  task automatic run_seq(input string tag, input int exp_busy, input logic [1:0] exp_priv,
                         input bit keep_irq);
    int b0, f0;
    b0 = busy_cnt;
    f0 = flush_cnt;
    step();
    exc_valid = 1'b0; mret = 1'b0; sret = 1'b0;
    if (!keep_irq) irq_valid = 1'b0;
    check({tag, "_started"}, 32'(busy), 1);
    wait_idle(tag);
    finish_seq(tag, b0, f0, exp_busy, exp_priv);
  endtask

  initial begin
    int b0, f0;
    logic [11:0]     held_addr;
    logic [XLEN-1:0] held_data;

    rst_n = 1'b0;
    exc_valid = 0; irq_valid = 0; mret = 0; sret = 0;
    exc_cause = 0; exc_tval = 0; exc_pc = 0; exc_target_priv = 0; exc_vector = 0;
    irq_cause = 0; irq_pc = 0; irq_target_priv = 0; irq_vector = 0;
    mepc_in = 32'h400; sepc_in = 32'h700; status_in = 0;
    csr_wr.csr_wr_ready = 1'b1;

    // Reset state
    repeat (2) step();
    check("rst_csr_valid", 32'(csr_wr.csr_wr_valid), 0);
    check("rst_csr_addr", 32'(csr_wr.csr_wr_addr), 0);
    check("rst_csr_data", csr_wr.csr_wr_data, 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_redirect_valid", 32'(pc_redirect_valid), 0);
    check("rst_redirect_target", pc_redirect_target, 0);
    check("rst_trap_taken", 32'(trap_taken), 0);
    check("rst_priv", 32'(priv_mode), 3);
    #2 rst_n = 1'b1;
    step();

    // mret in M: MPP=00, MPIE=1
    status_in = 32'h80;
    mret = 1'b1;
    push_wr(12'h300, 32'h88);
    push_rd(32'h400, 1'b0);
    run_seq("mret_m", 3, 2'b00, 1'b0);

    // mret in U is ignored
    step();
    b0 = busy_cnt;
    mret = 1'b1;
    step();
    mret = 1'b0;
    check("mret_u_busy_now", 32'(busy), 0);
    repeat (3) step();
    check("mret_u_busy_cycles", busy_cnt - b0, 0);
    check("mret_u_priv", 32'(priv_mode), 0);

    // U-mode exception to M
    status_in = 32'h8;
    set_exc(32'd2, 32'hDEAD, 32'h100, 2'b11, 32'h8000);
    push_wr(12'h341, 32'h100);
    push_wr(12'h342, 32'd2);
    push_wr(12'h343, 32'hDEAD);
    push_wr(12'h300, 32'h80);
    push_rd(32'h8000, 1'b1);
    run_seq("exc_u", 6, 2'b11, 1'b0);

    // Back to U
    step();
    status_in = 32'h80;
    mret = 1'b1;
    push_wr(12'h300, 32'h88);
    push_rd(32'h400, 1'b0);
    run_seq("mret_m2", 3, 2'b00, 1'b0);

    // Delegated S-mode interrupt from U
    step();
    status_in = 32'h2;
    set_irq(32'h80000005, 32'h200, 2'b01, 32'h9000);
    push_wr(12'h141, 32'h200);
    push_wr(12'h142, 32'h80000005);
    push_wr(12'h143, 32'h0);
    push_wr(12'h300, 32'h20);
    push_rd(32'h9000, 1'b1);
    run_seq("irq_s", 6, 2'b01, 1'b0);

    // Exception from S to M with ready low for 3 cycles in WR_CAUSE
    step();
    status_in = 32'h0;
    set_exc(32'd7, 32'h55, 32'h300, 2'b11, 32'h8000);
    push_wr(12'h341, 32'h300);
    push_wr(12'h342, 32'd7);
    push_wr(12'h343, 32'h55);
    push_wr(12'h300, 32'h800);
    push_rd(32'h8000, 1'b1);
    b0 = busy_cnt;
    f0 = flush_cnt;
    step();
    exc_valid = 1'b0;
    check("stall_flush", 32'(flush), 1);
    step();
    check("stall_epc_addr", 32'(csr_wr.csr_wr_addr), 32'h341);
    step();
    csr_wr.csr_wr_ready = 1'b0;
    held_addr = csr_wr.csr_wr_addr;
    held_data = csr_wr.csr_wr_data;
    check("stall_cause_addr", 32'(held_addr), 32'h342);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid_held", 32'(csr_wr.csr_wr_valid), 1);
      check("stall_addr_held", 32'(csr_wr.csr_wr_addr), 32'(held_addr));
      check("stall_data_held", csr_wr.csr_wr_data, held_data);
    end
    csr_wr.csr_wr_ready = 1'b1;
    wait_idle("stall");
    finish_seq("stall", b0, f0, 9, 2'b11);

    // Exception, interrupt and mret together: exception first, then held irq
    step();
    status_in = 32'h8;
    set_exc(32'd4, 32'h11, 32'h500, 2'b11, 32'hB000);
    set_irq(32'h80000007, 32'h600, 2'b11, 32'hA000);
    mret = 1'b1;
    push_wr(12'h341, 32'h500);
    push_wr(12'h342, 32'd4);
    push_wr(12'h343, 32'h11);
    push_wr(12'h300, 32'h1880);
    push_rd(32'hB000, 1'b1);
    run_seq("exc_first", 6, 2'b11, 1'b1);
    push_wr(12'h341, 32'h600);
    push_wr(12'h342, 32'h80000007);
    push_wr(12'h343, 32'h0);
    push_wr(12'h300, 32'h1880);
    push_rd(32'hA000, 1'b1);
    run_seq("irq_second", 6, 2'b11, 1'b0);

    // sret from M with SPP=1, SPIE=1
    step();
    status_in = 32'h120;
    sret = 1'b1;
    push_wr(12'h300, 32'h22);
    push_rd(32'h700, 1'b0);
    run_seq("sret", 3, 2'b01, 1'b0);

    // Reset during WR_TVAL of an S-target exception from S
    step();
    status_in = 32'h0;
    set_exc(32'd8, 32'h77, 32'h900, 2'b01, 32'hC000);
    push_wr(12'h141, 32'h900);
    push_wr(12'h142, 32'd8);
    step();
    exc_valid = 1'b0;
    repeat (3) step();
    check("tval_valid_before_rst", 32'(csr_wr.csr_wr_valid), 1);
    check("tval_addr_before_rst", 32'(csr_wr.csr_wr_addr), 32'h143);
    #1 rst_n = 1'b0;
    #1;
    check("abort_csr_valid", 32'(csr_wr.csr_wr_valid), 0);
    check("abort_priv", 32'(priv_mode), 3);
    check("abort_busy", 32'(busy), 0);
    check("abort_redirect", 32'(pc_redirect_valid), 0);
    repeat (2) step();
    #2 rst_n = 1'b1;
    check("abort_writes_drained", wr_q.size(), 0);
    step();

    // Normal exception after reset release
    set_exc(32'd3, 32'h0, 32'hA00, 2'b11, 32'h8000);
    push_wr(12'h341, 32'hA00);
    push_wr(12'h342, 32'd3);
    push_wr(12'h343, 32'h0);
    push_wr(12'h300, 32'h1800);
    push_rd(32'h8000, 1'b1);
    run_seq("post_rst_exc", 6, 2'b11, 1'b0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
